mips_cpu_hilo: RTL and testbench

HI/LO special-register unit of the MIPS32 core, sitting directly downstream of `mips_cpu_multiplier` and the multi-cycle divider. It owns the multiplier's registered operands, sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO, and captures the 64-bit product or quotient/remainder into HI/LO. While a result is pending it asserts `stall`, so the core's MFHI/MFLO and further HI/LO ops wait.

---
 rtl/mips_cpu_hilo.sv | 141 ++++++++++++++
 tb/tb_mips_cpu_hilo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo.sv
// HI/LO special-register unit: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns
// the registered operands handed to the external multiplier and divider.
module mips_cpu_hilo #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_req,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_product,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        stall
);

    // cnt only ever holds MUL_LATENCY-1 down to 0
    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_DIVU  = 3'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          issue_mul, issue_div, wr_hi, wr_lo, cap_mul, cap_div;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        issue_mul = 1'b0;
        issue_div = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        cap_mul   = 1'b0;
        cap_div   = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            issue_mul = 1'b1;
                            state_n   = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            issue_div = 1'b1;
                            state_n   = DIV_WAIT;
                        end
                        OP_MTHI: wr_hi = 1'b1;
                        OP_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                if (cnt == '0) begin
                    cap_mul = 1'b1;
                    state_n = IDLE;
                end
            end
            DIV_WAIT: begin
                // divide-by-zero results are taken exactly as the divider delivers them
                if (div_done) begin
                    cap_div = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_sign     <= 1'b0;
            div_start    <= 1'b0;
            div_sign     <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            hi_out       <= '0;
            lo_out       <= '0;
        end else begin
            div_start <= issue_div;
            if (issue_mul) begin
                mul_a    <= rs_data;
                mul_b    <= rt_data;
                mul_sign <= (op == OP_MULT);
                cnt      <= CW'(MUL_LATENCY - 1);
            end else if (state == MUL_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (issue_div) begin
                div_dividend <= rs_data;
                div_divisor  <= rt_data;
                div_sign     <= (op == OP_DIV);
            end
            if (cap_mul) begin
                hi_out <= mul_product[63:32];
                lo_out <= mul_product[31:0];
            end else if (cap_div) begin
                hi_out <= div_remainder;
                lo_out <= div_quotient;
            end else begin
                if (wr_hi) hi_out <= rs_data;
                if (wr_lo) lo_out <= rs_data;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (rd_req | op_valid);

endmodule

// File: tb/tb_mips_cpu_hilo.sv
// Bench for mips_cpu_hilo: two instances (multiplier latency 1 and 3) share one
// stimulus stream; expected HI/LO and busy timing come from plain arithmetic.
module tb_mips_cpu_hilo;

    logic        clk = 1'b0;
    logic        reset, op_valid, rd_req, div_done;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, div_q, div_r;

    logic [31:0] mul_a [2];
    logic [31:0] mul_b [2];
    logic        mul_sign [2];
    logic [63:0] mul_product [2];
    logic        div_start [2];
    logic        div_sign [2];
    logic [31:0] div_dividend [2];
    logic [31:0] div_divisor [2];
    logic [31:0] hi [2];
    logic [31:0] lo [2];
    logic        busy [2];
    logic        stall [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    function automatic logic [63:0] mprod(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // ideal multiplier: product settles well before the capture edge
    assign mul_product[0] = mprod(mul_a[0], mul_b[0], mul_sign[0]);
    assign mul_product[1] = mprod(mul_a[1], mul_b[1], mul_sign[1]);

    mips_cpu_hilo #(.MUL_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .rd_req(rd_req),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_sign(mul_sign[0]), .mul_product(mul_product[0]),
        .div_start(div_start[0]), .div_sign(div_sign[0]),
        .div_dividend(div_dividend[0]), .div_divisor(div_divisor[0]),
        .div_done(div_done), .div_quotient(div_q), .div_remainder(div_r),
        .hi_out(hi[0]), .lo_out(lo[0]), .busy(busy[0]), .stall(stall[0])
    );

    mips_cpu_hilo #(.MUL_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .rd_req(rd_req),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_sign(mul_sign[1]), .mul_product(mul_product[1]),
        .div_start(div_start[1]), .div_sign(div_sign[1]),
        .div_dividend(div_dividend[1]), .div_divisor(div_divisor[1]),
        .div_done(div_done), .div_quotient(div_q), .div_remainder(div_r),
        .hi_out(hi[1]), .lo_out(lo[1]), .busy(busy[1]), .stall(stall[1])
    );

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_hl(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_hi"}, i, 64'(hi[i]), 64'(exp_hi));
            chk({tag, "_lo"}, i, 64'(lo[i]), 64'(exp_lo));
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        op_valid = 1'b0;
        op       = 3'd0;
        rd_req   = 1'b0;
        div_done = 1'b0;
    endtask

    // issue a multiply; optionally present an MTHI while the unit is busy
    task automatic do_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit intrude);
        logic [63:0] p;
        p        = mprod(a, b, o == 3'd1);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b; rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                for (int i = 0; i < 2; i++) begin
                    chk("mul_a", i, 64'(mul_a[i]), 64'(a));
                    chk("mul_b", i, 64'(mul_b[i]), 64'(b));
                    chk("mul_sign", i, 64'(mul_sign[i]), 64'(o == 3'd1));
                end
                op_valid = 1'b0;
                if (intrude) begin
                    op_valid = 1'b1; op = 3'd3; rs_data = ~a;
                end
            end else begin
                op_valid = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                chk("mul_busy", i, 64'(busy[i]), 64'(k < lat(i)));
                chk("mul_stall", i, 64'(stall[i]), 64'(k < lat(i)));
                chk("mul_hi", i, 64'(hi[i]), 64'((k >= lat(i)) ? p[63:32] : exp_hi));
                chk("mul_lo", i, 64'(lo[i]), 64'((k >= lat(i)) ? p[31:0] : exp_lo));
            end
        end
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        idle_in();
    endtask

    // issue a divide; the modelled divider answers dly cycles after div_start
    task automatic do_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int dly);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a; sb = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (o == 3'd5) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        step();
        op_valid = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("div_start_on", i, 64'(div_start[i]), 64'd1);
            chk("div_sign", i, 64'(div_sign[i]), 64'(o == 3'd5));
            chk("div_dividend", i, 64'(div_dividend[i]), 64'(a));
            chk("div_divisor", i, 64'(div_divisor[i]), 64'(b));
            chk("div_stall", i, 64'(stall[i]), 64'd1);
        end
        for (int d = 1; d <= dly; d++) begin
            if (d == dly) begin
                div_done = 1'b1; div_q = q; div_r = r;
            end
            step();
            div_done = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk("div_start_off", i, 64'(div_start[i]), 64'd0);
                chk("div_busy", i, 64'(busy[i]), 64'(d < dly));
                chk("div_hi", i, 64'(hi[i]), 64'((d == dly) ? r : exp_hi));
                chk("div_lo", i, 64'(lo[i]), 64'((d == dly) ? q : exp_lo));
            end
        end
        exp_hi = r;
        exp_lo = q;
        idle_in();
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] v);
        op_valid = 1'b1; op = o; rs_data = v; rd_req = 1'b1;
        #1;
        chk_hl("mt_noforward");
        for (int i = 0; i < 2; i++) chk("mt_stall", i, 64'(stall[i]), 64'd0);
        step();
        idle_in();
        if (o == 3'd3) exp_hi = v;
        else           exp_lo = v;
        chk_hl("mt_after");
        for (int i = 0; i < 2; i++) chk("mt_busy", i, 64'(busy[i]), 64'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        idle_in();
        rs_data = '0; rt_data = '0; div_q = '0; div_r = '0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_hi", i, 64'(hi[i]), 64'd0);
            chk("rst_lo", i, 64'(lo[i]), 64'd0);
            chk("rst_mul_a", i, 64'(mul_a[i]), 64'd0);
            chk("rst_mul_b", i, 64'(mul_b[i]), 64'd0);
            chk("rst_mul_sign", i, 64'(mul_sign[i]), 64'd0);
            chk("rst_div_start", i, 64'(div_start[i]), 64'd0);
            chk("rst_div_sign", i, 64'(div_sign[i]), 64'd0);
            chk("rst_dividend", i, 64'(div_dividend[i]), 64'd0);
            chk("rst_divisor", i, 64'(div_divisor[i]), 64'd0);
            chk("rst_busy", i, 64'(busy[i]), 64'd0);
        end

        do_mul(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_neg3x5", 0, {hi[0], lo[0]}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mul(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max", 1, {hi[1], lo[1]}, 64'hFFFF_FFFE_0000_0001);
        do_div(3'd5, 32'hFFFF_FFF9, 32'd2, 5);
        chk("div_neg7by2", 0, {hi[0], lo[0]}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_mt(3'd3, 32'h1234_5678);
        do_mt(3'd4, 32'h9ABC_DEF0);
        do_mul(3'd2, 32'd2, 32'd3, 1'b0);
        chk("multu_2x3", 1, {hi[1], lo[1]}, 64'h0000_0000_0000_0006);
        do_mul(3'd1, $urandom, $urandom, 1'b1);
        do_div(3'd6, 32'h0000_1234, 32'd0, 1);

        // stray div_done while idle must not touch HI/LO
        div_done = 1'b1; div_q = $urandom; div_r = $urandom;
        step();
        div_done = 1'b0;
        chk_hl("stray_done");

        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case (o)
                3'd1, 3'd2: do_mul(o, a, b, 1'($urandom_range(0, 1)));
                3'd5, 3'd6: begin
                    if (b == 0) b = 32'd1;
                    if (o == 3'd5 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
                    do_div(o, a, b, $urandom_range(1, 6));
                end
                3'd3, 3'd4: do_mt(o, a);
                default: begin
                    op_valid = 1'b1; op = o; rs_data = a;
                    step();
                    idle_in();
                    chk_hl("nop");
                    for (int i = 0; i < 2; i++) chk("nop_busy", i, 64'(busy[i]), 64'd0);
                end
            endcase
        end

        // reset while a DIVU is outstanding, then a late div_done
        op_valid = 1'b1; op = 3'd6; rs_data = 32'd100; rt_data = 32'd7;
        step();
        op_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk_hl("abort");
        for (int i = 0; i < 2; i++) chk("abort_busy", i, 64'(busy[i]), 64'd0);
        div_done = 1'b1; div_q = 32'd14; div_r = 32'd2;
        step();
        div_done = 1'b0;
        chk_hl("late_done");
        for (int i = 0; i < 2; i++) begin
            chk("late_busy", i, 64'(busy[i]), 64'd0);
            chk("late_start", i, 64'(div_start[i]), 64'd0);
        end
        do_mt(3'd3, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
